// File: rtl/barrett_pipelined_pkg.sv
// Shared constants and stage record for the pipelined Barrett reducer.
// DATA_LENGTH sets the datapath width; MODULUS/MODULUS_LENGTH/MU are the
// Dilithium reduction constants (q, k = bitlength(q), floor(2^(2k)/q)).
package barrett_pipelined_pkg;

  localparam int unsigned DATA_LENGTH    = 64;
  localparam logic [63:0] MODULUS        = 64'd8380417;
  localparam int unsigned MODULUS_LENGTH = 23;
  localparam logic [63:0] MU             = 64'd8396807;
  localparam int unsigned LATENCY        = 5;

  // Full product width of the two pipeline multipliers.
  localparam int unsigned PROD_W = 2 * DATA_LENGTH;
  // Only the low bits of q_bl are meaningful (k <= 64).
  localparam int unsigned K_W    = 7;

  // One pipeline entry: the operand travels with its own modulus constants so the
  // modulus may change from sample to sample.
  typedef struct packed {
    logic                   valid;
    logic [DATA_LENGTH-1:0] x;
    logic [DATA_LENGTH-1:0] q;
    logic [K_W-1:0]         k;
    logic [DATA_LENGTH-1:0] mu;
    logic [DATA_LENGTH:0]   data;
  } stage_t;

endpackage

// File: rtl/barrett_pipelined_mult.sv
// Registered unsigned multiplier with load enable.
// Ports:
//   clk_i  clock, rising edge
//   rst_i  asynchronous active-high reset, clears the product
//   en_i   load enable; product register updates only when high
//   a_i    multiplicand, Width bits
//   b_i    multiplier, Width bits
//   p_o    registered full product, 2*Width bits
module barrett_pipelined_mult #(
  parameter int unsigned Width = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [Width-1:0]   a_i,
  input  logic [Width-1:0]   b_i,
  output logic [2*Width-1:0] p_o
);

  logic [2*Width-1:0] p_q, p_d;

  always_comb begin
    p_d = p_q;
    if (en_i) begin
      p_d = a_i * b_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

  assign p_o = p_q;

endmodule

// File: rtl/barrett_pipelined.sv
// Fully pipelined Barrett reduction: result_o = x_i mod q_i for x_i < 2^(2k).
// One operand per clock, results emerge LATENCY (5) edges later in order.
// Ports:
//   CLK_pci_sys_clk_p  system clock, rising edge
//   rst_ni             asynchronous reset, active HIGH despite the name
//   start_i            input valid; x_i/q_i/q_bl_i/mu_i sampled when high
//   x_i                operand
//   q_i                modulus q (odd, > 1)
//   q_bl_i             k = bitlength(q), low 7 bits used
//   mu_i               floor(2^(2k)/q)
//   result_o           x mod q, holds the last valid result between valids
//   valid_o            result_o valid this cycle
module barrett_pipelined
  import barrett_pipelined_pkg::*;
(
  input  logic                   CLK_pci_sys_clk_p,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [DATA_LENGTH-1:0] x_i,
  input  logic [DATA_LENGTH-1:0] q_i,
  input  logic [DATA_LENGTH-1:0] q_bl_i,
  input  logic [DATA_LENGTH-1:0] mu_i,
  output logic [DATA_LENGTH-1:0] result_o,
  output logic                   valid_o
);

  stage_t s1_q, s1_d, s2_q, s2_d, s3_q, s3_d, s4_q, s4_d;
  logic [DATA_LENGTH-1:0] result_q, result_d;
  logic                   valid_q, valid_d;

  logic [PROD_W-1:0]      q2;
  logic [PROD_W-1:0]      q3;
  logic [PROD_W-1:0]      m_full;
  logic [7:0]             shift3;
  logic [DATA_LENGTH:0]   r_s1, r_s2, q_ext;

  // S1: q1 = x >> (k-1)
  always_comb begin
    s1_d       = s1_q;
    s1_d.valid = start_i;
    if (start_i) begin
      s1_d.x    = x_i;
      s1_d.q    = q_i;
      s1_d.k    = q_bl_i[K_W-1:0];
      s1_d.mu   = mu_i;
      s1_d.data = {1'b0, x_i >> (q_bl_i[K_W-1:0] - 7'd1)};
    end
  end

  // S2: q2 = q1 * mu, product held inside the multiplier
  barrett_pipelined_mult #(
    .Width (DATA_LENGTH)
  ) u_mult_s2 (
    .clk_i (CLK_pci_sys_clk_p),
    .rst_i (rst_ni),
    .en_i  (s1_q.valid),
    .a_i   (s1_q.data[DATA_LENGTH-1:0]),
    .b_i   (s1_q.mu),
    .p_o   (q2)
  );

  always_comb begin
    s2_d       = s2_q;
    s2_d.valid = s1_q.valid;
    if (s1_q.valid) begin
      s2_d = s1_q;
    end
  end

  // S3: q3 = q2 >> (k+1); m = q3 * q. For legal operands q3 < 2^k, so its low
  // DATA_LENGTH bits are exact.
  assign shift3 = {1'b0, s2_q.k} + 8'd1;
  assign q3     = q2 >> shift3;

  barrett_pipelined_mult #(
    .Width (DATA_LENGTH)
  ) u_mult_s3 (
    .clk_i (CLK_pci_sys_clk_p),
    .rst_i (rst_ni),
    .en_i  (s2_q.valid),
    .a_i   (q3[DATA_LENGTH-1:0]),
    .b_i   (s2_q.q),
    .p_o   (m_full)
  );

  always_comb begin
    s3_d       = s3_q;
    s3_d.valid = s2_q.valid;
    if (s2_q.valid) begin
      s3_d = s2_q;
    end
  end

  // S4: r = x - m, lands in [0, 3q) for consistent mu
  always_comb begin
    s4_d       = s4_q;
    s4_d.valid = s3_q.valid;
    if (s3_q.valid) begin
      s4_d      = s3_q;
      s4_d.data = {1'b0, s3_q.x} - m_full[DATA_LENGTH:0];
    end
  end

  // S5: two conditional subtractions bring r into [0, q)
  always_comb begin
    q_ext    = {1'b0, s4_q.q};
    r_s1     = (s4_q.data >= q_ext) ? (s4_q.data - q_ext) : s4_q.data;
    r_s2     = (r_s1 >= q_ext) ? (r_s1 - q_ext) : r_s1;
    valid_d  = s4_q.valid;
    result_d = result_q;
    if (s4_q.valid) begin
      result_d = r_s2[DATA_LENGTH-1:0];
    end
  end

  always_ff @(posedge CLK_pci_sys_clk_p or posedge rst_ni) begin
    if (rst_ni) begin
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
      s4_q     <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      s4_q     <= s4_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign result_o = result_q;
  assign valid_o  = valid_q;

endmodule

// File: tb/tb_barrett_pipelined.sv
// Scoreboard bench for barrett_pipelined with the Dilithium constants.
module tb_barrett_pipelined;
  import barrett_pipelined_pkg::*;

  localparam logic [63:0] Q  = 64'd8380417;
  localparam logic [63:0] K  = 64'd23;
  localparam logic [63:0] M  = 64'd8396807;
  localparam logic [63:0] Q2 = Q * Q;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [63:0] x_i = '0;
  logic [63:0] result_o;
  logic        valid_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [63:0] sb[$];
  bit   [4:0]  vpipe = '0;
  bit          exp_v;
  logic [63:0] exp_r;
  logic [63:0] last_r = '0;

  always #5 clk = ~clk;

  barrett_pipelined dut (
    .CLK_pci_sys_clk_p (clk),
    .rst_ni            (rst),
    .start_i           (start_i),
    .x_i               (x_i),
    .q_i               (Q),
    .q_bl_i            (K),
    .mu_i              (M),
    .result_o          (result_o),
    .valid_o           (valid_o)
  );

  // Advance one cycle: update the expected valid/result for the edge just passed,
  // then present the next input and record its expected result.
  task automatic drive(input bit s, input logic [63:0] x);
    @(negedge clk);
    vpipe = {vpipe[3:0], start_i};
    exp_v = vpipe[4];
    if (exp_v && sb.size() > 0) begin
      exp_r  = sb.pop_front();
      last_r = exp_r;
    end else begin
      exp_r = last_r;
    end
    start_i = s;
    x_i     = x;
    if (s) sb.push_back(x % Q);
  endtask

  task automatic model_clear();
    vpipe  = '0;
    sb.delete();
    last_r = '0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (valid_o !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_valid: got %b want 0", valid_o);
    end
    n_checks++;
    if (result_o !== 64'd0) begin
      n_errors++;
      $display("FAIL reset_result: got %0d want 0", result_o);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_single_zero();
    int nv = 0;
    drive(1'b1, 64'd0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 64'd0);
      if (valid_o === 1'b1) nv++;
      n_checks++;
      if (valid_o !== exp_v) begin
        n_errors++;
        $display("FAIL single_valid cyc %0d: got %b want %b", i, valid_o, exp_v);
      end
      n_checks++;
      if (result_o !== exp_r) begin
        n_errors++;
        $display("FAIL single_result cyc %0d: got %0d want %0d", i, result_o, exp_r);
      end
    end
    n_checks++;
    if (nv != 1) begin
      n_errors++;
      $display("FAIL single_count: got %0d valid cycles want 1", nv);
    end
  endtask

  task automatic test_boundary();
    logic [63:0] xs[5];
    xs[0] = Q - 1;
    xs[1] = Q;
    xs[2] = Q + 1;
    xs[3] = 64'd70231372333056;
    xs[4] = Q2 - 1;
    for (int i = 0; i < 12; i++) begin
      if (i < 5) drive(1'b1, xs[i]);
      else drive(1'b0, 64'd0);
      n_checks++;
      if (valid_o !== exp_v) begin
        n_errors++;
        $display("FAIL boundary_valid cyc %0d: got %b want %b", i, valid_o, exp_v);
      end
      n_checks++;
      if (result_o !== exp_r) begin
        n_errors++;
        $display("FAIL boundary_result cyc %0d: got %0d want %0d", i, result_o, exp_r);
      end
    end
  endtask

  task automatic test_back_to_back();
    int nv = 0;
    logic [63:0] x;
    for (int i = 0; i < 23; i++) begin
      x = {$urandom(), $urandom()} % Q2;
      if (i < 16) drive(1'b1, x);
      else drive(1'b0, 64'd0);
      if (valid_o === 1'b1) nv++;
      n_checks++;
      if (valid_o !== exp_v) begin
        n_errors++;
        $display("FAIL stream_valid cyc %0d: got %b want %b", i, valid_o, exp_v);
      end
      n_checks++;
      if (result_o !== exp_r) begin
        n_errors++;
        $display("FAIL stream_result cyc %0d: got %0d want %0d", i, result_o, exp_r);
      end
    end
    // Item 16 emerges on the 5th drive after it; the remaining tail ends at 23.
    n_checks++;
    if (nv != 16) begin
      n_errors++;
      $display("FAIL stream_count: got %0d valid cycles want 16", nv);
    end
  endtask

  task automatic test_gaps();
    logic [63:0] x;
    for (int i = 0; i < 26; i++) begin
      x = {$urandom(), $urandom()} % Q2;
      if (i < 18 && (i % 3) == 0) drive(1'b1, x);
      else drive(1'b0, 64'd0);
      n_checks++;
      if (valid_o !== exp_v) begin
        n_errors++;
        $display("FAIL gaps_valid cyc %0d: got %b want %b", i, valid_o, exp_v);
      end
      n_checks++;
      if (result_o !== exp_r) begin
        n_errors++;
        $display("FAIL gaps_result cyc %0d: got %0d want %0d", i, result_o, exp_r);
      end
    end
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 64'd1000000);
    drive(1'b1, Q2 - 2);
    drive(1'b1, 64'd77777777);
    drive(1'b0, 64'd0);
    drive(1'b0, 64'd0);
    drive(1'b0, 64'd0);
    n_checks++;
    if (valid_o !== 1'b1 || result_o !== exp_r) begin
      n_errors++;
      $display("FAIL pre_reset: got %b/%0d want 1/%0d", valid_o, result_o, exp_r);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (valid_o !== 1'b0) begin
      n_errors++;
      $display("FAIL midreset_valid: got %b want 0", valid_o);
    end
    n_checks++;
    if (result_o !== 64'd0) begin
      n_errors++;
      $display("FAIL midreset_result: got %0d want 0", result_o);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    drive(1'b1, 64'd12345);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 64'd0);
      n_checks++;
      if (valid_o !== exp_v) begin
        n_errors++;
        $display("FAIL postreset_valid cyc %0d: got %b want %b", i, valid_o, exp_v);
      end
      n_checks++;
      if (result_o !== exp_r) begin
        n_errors++;
        $display("FAIL postreset_result cyc %0d: got %0d want %0d", i, result_o, exp_r);
      end
    end
    n_checks++;
    if (result_o !== 64'd12345) begin
      n_errors++;
      $display("FAIL postreset_final: got %0d want 12345", result_o);
    end
  endtask

  initial begin
    test_reset();
    test_single_zero();
    test_boundary();
    test_back_to_back();
    test_gaps();
    test_reset_midstream();
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
